// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache responder with an Avalon-style refill port.
// Optional hit/miss counters are compiled in with `define ICACHE_STATS_EN.
module icache_responder #(
   parameter int unsigned LINES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_p_read,
   input  logic [31:0] i_p_addr,
   output logic [31:0] o_p_readdata,
   output logic        o_p_waitrequest,
   input  logic        i_flush,
   output logic        o_m_read,
   output logic [31:0] o_m_addr,
   input  logic [31:0] i_m_readdata,
   input  logic        i_m_waitrequest
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] o_hit_cnt,
   output logic [31:0] o_miss_cnt
`endif
);

   localparam int unsigned IDX   = $clog2(LINES);
   localparam int unsigned TAG_W = 30 - IDX;

   typedef enum logic [1:0] {LOOKUP, MEM_RD, REFILL} state_t;

   state_t             state, state_nxt;
   logic [LINES-1:0]   valid;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [31:0]        data_mem [LINES];
   logic [29:0]        miss_word;

   logic [IDX-1:0]     req_idx, fill_idx;
   logic [TAG_W-1:0]   req_tag, fill_tag;
   logic               hit;
   logic               miss_ld;
   logic               fill;
   logic               addr_unused;

   assign req_idx     = i_p_addr[IDX+1:2];
   assign req_tag     = i_p_addr[31:IDX+2];
   assign fill_idx    = miss_word[IDX-1:0];
   assign fill_tag    = miss_word[29:IDX];
   assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign addr_unused = ^i_p_addr[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LOOKUP;
         valid     <= '0;
         miss_word <= '0;
      end else begin
         state <= state_nxt;
         if (miss_ld)
            miss_word <= i_p_addr[31:2];
         // flush beats a fill landing on the same edge
         if (i_flush)
            valid <= '0;
         else if (fill)
            valid[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= i_m_readdata;
      end
   end

   always_comb begin
      state_nxt       = state;
      o_p_waitrequest = 1'b1;
      o_p_readdata    = '0;
      o_m_read        = 1'b0;
      o_m_addr        = '0;
      miss_ld         = 1'b0;
      fill            = 1'b0;
      if (rst) begin
         unique case (state)
            LOOKUP: begin
               o_p_waitrequest = 1'b0;
               if (i_p_read) begin
                  if (hit) begin
                     o_p_readdata = data_mem[req_idx];
                  end else begin
                     o_p_waitrequest = 1'b1;
                     miss_ld         = 1'b1;
                     state_nxt       = MEM_RD;
                  end
               end
            end
            MEM_RD: begin
               o_m_read = 1'b1;
               o_m_addr = {miss_word, 2'b00};
               if (!i_m_waitrequest) begin
                  fill      = 1'b1;
                  state_nxt = REFILL;
               end
            end
            REFILL: state_nxt = LOOKUP;
            default: state_nxt = LOOKUP;
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   logic hit_evt;
   assign hit_evt = (state == LOOKUP) && i_p_read && hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_hit_cnt  <= '0;
         o_miss_cnt <= '0;
      end else begin
         if (hit_evt)
            o_hit_cnt <= o_hit_cnt + 32'd1;
         if (miss_ld)
            o_miss_cnt <= o_miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Randomized and directed bench for icache_responder against a line-table reference model.
// Counter checks are added when ICACHE_STATS_EN is defined.
module tb_icache_responder;

   localparam int unsigned LINES = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_p_read = 1'b0;
   logic [31:0] i_p_addr = '0;
   logic [31:0] o_p_readdata;
   logic        o_p_waitrequest;
   logic        i_flush = 1'b0;
   logic        o_m_read;
   logic [31:0] o_m_addr;
   logic [31:0] i_m_readdata = '0;
   logic        i_m_waitrequest = 1'b1;
`ifdef ICACHE_STATS_EN
   logic [31:0] o_hit_cnt;
   logic [31:0] o_miss_cnt;
`endif

   icache_responder #(.LINES(LINES)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_p_read        (i_p_read),
      .i_p_addr        (i_p_addr),
      .o_p_readdata    (o_p_readdata),
      .o_p_waitrequest (o_p_waitrequest),
      .i_flush         (i_flush),
      .o_m_read        (o_m_read),
      .o_m_addr        (o_m_addr),
      .i_m_readdata    (i_m_readdata),
      .i_m_waitrequest (i_m_waitrequest)
`ifdef ICACHE_STATS_EN
      ,
      .o_hit_cnt       (o_hit_cnt),
      .o_miss_cnt      (o_miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // reference model: per-line presence plus the progress of the one outstanding miss
   bit          mv        [LINES];
   logic [31:0] line_addr [LINES];
   logic [31:0] mdata     [LINES];
   int          busy = 0;
   int          mw   = 0;
   logic [31:0] maddr = '0;
   int unsigned m_hits = 0, m_misses = 0;

   logic [31:0] obs_wr, obs_rd, obs_mread, obs_maddr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h10)
         return 32'h0051_0113;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int unsigned line_of(input logic [31:0] a);
      return (a >> 2) % LINES;
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      int unsigned li;
      li = line_of(a);
      return mv[li] && (line_addr[li] == {a[31:2], 2'b00});
   endfunction

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
   endtask

   // One clock cycle: drive at posedge+1, compare at posedge+4, then advance the model.
   task automatic cycle(input bit rd, input logic [31:0] a, input bit fl, input int w);
      logic [31:0] ewr, erd, emr, ema;
      bit h;
      int unsigned li;
      @(posedge clk);
      #1;
      i_p_read = rd;
      i_p_addr = a;
      i_flush  = fl;
      h  = model_hit(a);
      li = line_of(a);
      if (busy == 0) begin
         ewr = {31'b0, rd && !h};
         erd = (rd && h) ? mdata[li] : 32'h0;
         emr = 32'h0;
         ema = 32'h0;
         i_m_waitrequest = 1'($urandom_range(0, 1));
         i_m_readdata    = $urandom;
      end else if (busy <= mw + 1) begin
         ewr = 32'h1;
         erd = 32'h0;
         emr = 32'h1;
         ema = maddr;
         i_m_waitrequest = (busy <= mw);
         i_m_readdata    = i_m_waitrequest ? $urandom : mem_word(maddr);
      end else begin
         ewr = 32'h1;
         erd = 32'h0;
         emr = 32'h0;
         ema = 32'h0;
         i_m_waitrequest = 1'($urandom_range(0, 1));
         i_m_readdata    = $urandom;
      end
      #3;
      obs_wr    = {31'b0, o_p_waitrequest};
      obs_rd    = o_p_readdata;
      obs_mread = {31'b0, o_m_read};
      obs_maddr = o_m_addr;
      check("p_waitrequest", obs_wr, ewr);
      check("p_readdata", obs_rd, erd);
      check("m_read", obs_mread, emr);
      check("m_addr", obs_maddr, ema);
`ifdef ICACHE_STATS_EN
      check("hit_cnt", o_hit_cnt, m_hits);
      check("miss_cnt", o_miss_cnt, m_misses);
`endif
      if (busy == 0) begin
         if (rd && h) m_hits++;
         if (rd && !h) begin
            m_misses++;
            busy  = 1;
            maddr = {a[31:2], 2'b00};
            mw    = (w < 0) ? int'($urandom_range(0, 3)) : w;
         end
      end else if (busy == mw + 1) begin
         mv[line_of(maddr)]        = 1'b1;
         line_addr[line_of(maddr)] = maddr;
         mdata[line_of(maddr)]     = mem_word(maddr);
         busy++;
      end else if (busy <= mw) begin
         busy++;
      end else begin
         busy = 0;
      end
      if (fl) model_clear();
   endtask

   task automatic reset_now();
      i_p_read = 1'b0;
      i_flush  = 1'b0;
      rst      = 1'b0;
      #1;
      check("rst_waitrequest", {31'b0, o_p_waitrequest}, 32'h1);
      check("rst_readdata", o_p_readdata, 32'h0);
      check("rst_m_read", {31'b0, o_m_read}, 32'h0);
      check("rst_m_addr", o_m_addr, 32'h0);
      model_clear();
      busy     = 0;
      m_hits   = 0;
      m_misses = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic read_until_done(input logic [31:0] a, input int w,
                                  output int stalls, output logic [31:0] data);
      bit done;
      done   = 1'b0;
      stalls = 0;
      data   = '0;
      for (int n = 0; n < 30 && !done; n++) begin
         cycle(1'b1, a, 1'b0, w);
         if (obs_wr == 32'h0) begin
            done = 1'b1;
            data = obs_rd;
         end else begin
            stalls++;
         end
      end
      if (!done) check("read_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      int          stalls;
      logic [31:0] data;
      bit          rd;
      logic [31:0] a, held_a;
      bit          held_rd;

      model_clear();
      reset_now();

      // cold miss, W=0
      read_until_done(32'h10, 0, stalls, data);
      check("cold_stalls", stalls, 3);
      check("cold_data", data, 32'h0051_0113);

      // hit
      cycle(1'b1, 32'h10, 1'b0, 0);
      check("hit_wait", obs_wr, 32'h0);
      check("hit_data", obs_rd, 32'h0051_0113);
      check("hit_m_read", obs_mread, 32'h0);

      // conflict miss, same index different tag, W=2
      read_until_done(32'h110, 2, stalls, data);
      check("conflict_stalls", stalls, 5);
      check("conflict_data", data, mem_word(32'h110));
      read_until_done(32'h10, 0, stalls, data);
      check("reevict_stalls", stalls, 3);

      // flush on the edge the fill completes
      cycle(1'b1, 32'h2A4, 1'b0, 1);
      cycle(1'b1, 32'h2A4, 1'b0, 1);
      cycle(1'b1, 32'h2A4, 1'b1, 1);
      cycle(1'b1, 32'h2A4, 1'b0, 0);
      cycle(1'b1, 32'h2A4, 1'b0, 0);
      check("flushfill_remiss", obs_wr, 32'h1);
      cycle(1'b1, 32'h2A4, 1'b0, 0);
      check("flushfill_m_read", obs_mread, 32'h1);
      check("flushfill_m_addr", obs_maddr, 32'h2A4);
      read_until_done(32'h2A4, 0, stalls, data);
      check("flushfill_data", data, mem_word(32'h2A4));

      // reset during MEM_RD with the memory stalling
      cycle(1'b1, 32'h3C8, 1'b0, 5);
      cycle(1'b1, 32'h3C8, 1'b0, 5);
      reset_now();
      read_until_done(32'h3C8, 0, stalls, data);
      check("postrst_stalls", stalls, 3);

`ifdef ICACHE_STATS_EN
      reset_now();
      read_until_done(32'h40, 1, stalls, data);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h40, 1'b0, 0);
      cycle(1'b0, 32'h0, 1'b0, 0);
      check("stats_miss", o_miss_cnt, 32'd1);
      check("stats_hit", o_hit_cnt, 32'd4);
`endif

      // randomized traffic over a small address pool for hits, conflicts and flushes
      held_rd = 1'b0;
      held_a  = '0;
      for (int n = 0; n < 800; n++) begin
         if (busy == 0) begin
            rd = ($urandom_range(0, 3) != 0);
            a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            held_rd = rd;
            held_a  = a;
         end
         cycle(held_rd, held_a, ($urandom_range(0, 19) == 0), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/icache_responder.md
# icache_responder

Instruction-side memory responder behind the fetch stage. It serves fetch reads from a direct-mapped, one-word-per-line cache and drives `o_p_waitrequest` back to the fetch stage, so fetch only advances on valid data. Misses are filled from a backing memory over an Avalon-style read port with wait-request.

## Interface
- `LINES`, 64: number of cache lines; power of two, minimum 2. `IDX = log2(LINES)`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `i_p_read`  input  1  fetch read strobe.
- `i_p_addr`  input  32  fetch byte address; `[1:0]` ignored.
- `o_p_readdata`  output  32  instruction word; valid when `i_p_read && !o_p_waitrequest`.
- `o_p_waitrequest`  output  1  high = fetch must hold its pipeline register and address.
- `i_flush`  input  1  one-cycle pulse; invalidates all lines.
- `o_m_read`  output  1  backing-memory read request.
- `o_m_addr`  output  32  backing-memory word-aligned byte address.
- `i_m_readdata`  input  32  backing-memory data; valid in the cycle `o_m_read && !i_m_waitrequest`.
- `i_m_waitrequest`  input  1  backing memory stall.

## Operation
- Address split: index = `i_p_addr[IDX+1:2]`; tag = `i_p_addr[31:IDX+2]`. Per line: valid bit, tag, 32-bit data.
- Hit = `valid[index] && tag[index] == tag`, evaluated combinationally in LOOKUP.
- FSM states:
  - LOOKUP:
    - No read: `o_p_waitrequest=0`, `o_p_readdata=0`.
    - Read and hit: `o_p_waitrequest=0`, `o_p_readdata` = line data.
    - Read and miss: `o_p_waitrequest=1`, `o_p_readdata=0`; latch the word-aligned address into `miss_addr`; go to MEM_RD.
  - MEM_RD:
    - `o_m_read=1`, `o_m_addr=miss_addr`, `o_p_waitrequest=1`.
    - When `i_m_waitrequest=0`: write `i_m_readdata`, tag and valid=1 into the line selected by `miss_addr`; go to REFILL.
  - REFILL: `o_p_waitrequest=1`; go to LOOKUP unconditionally. This state gives a registered re-lookup.
- Requester rule: the requester holds `i_p_addr` while `o_p_waitrequest=1`. If the address changes anyway, the in-flight fill still completes to `miss_addr`, and the new address is looked up on return to LOOKUP.
- `o_m_read` is 0 outside MEM_RD. `o_m_addr` is 0 outside MEM_RD.
- Flush: when `i_flush=1`, clear all valid bits at the clock edge in any state.
  - Flush and fill completing on the same edge: flush wins, and the filled line ends invalid.
  - A flush during MEM_RD does not cancel the memory read.
- Reset (`rst=0`, asynchronous):
  - State goes to LOOKUP; all valid bits clear; `miss_addr=0`.
  - While `rst=0`: `o_p_waitrequest=1`, `o_p_readdata=0`, `o_m_read=0`, `o_m_addr=0`.
  - Reset mid-miss abandons the memory transaction immediately.
  - Tag and data arrays are not reset.

## Timing
- Hit: zero wait states. Data is returned in the same cycle the address is presented.
- Miss with memory wait W cycles (W=0 means accepted in its first MEM_RD cycle):
  - Cycle 0: LOOKUP miss.
  - Cycles 1..W+1: MEM_RD.
  - Cycle W+2: REFILL.
  - Cycle W+3: LOOKUP hit, with `o_p_waitrequest=0`.
  - Miss penalty = W+3 cycles of `o_p_waitrequest=1`.
- `o_m_read`/`o_m_addr` stay stable until `i_m_waitrequest` is sampled low; only one memory request is outstanding at a time.
- Outputs are combinational from state, the arrays and the `i_p_*` inputs; there is no path from `i_m_*` to `o_p_*`.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds two outputs, `o_hit_cnt` and `o_miss_cnt`, each 32 bits.
  - `o_hit_cnt` increments on each LOOKUP cycle with a read hit; `o_miss_cnt` increments on each LOOKUP-to-MEM_RD transition.
  - Both wrap at 2^32, clear to 0 on reset, and are unaffected by `i_flush`.
- `ICACHE_STATS_EN` undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Cold miss:
  - Stimulus: after reset, read 0x0000_0010; memory W=0 returns 0x0051_0113.
  - Required: waitrequest high for exactly 3 cycles; `o_m_addr=0x10` for 1 cycle; then readdata 0x0051_0113 with waitrequest low.
- Hit: re-read 0x0000_0010 -> waitrequest low in the same cycle, data 0x0051_0113, `o_m_read` stays 0.
- Conflict miss (LINES=64):
  - Stimulus: read 0x0000_0010, then 0x0000_0110 (same index, different tag); memory W=2.
  - Required: second read stalls 5 cycles; afterwards 0x10 misses again.
- Flush with fill: assert `i_flush` on the edge the fill completes -> the line stays invalid; the next LOOKUP misses and re-requests the same address.
- Reset mid-miss:
  - Stimulus: drop `rst` during MEM_RD with `i_m_waitrequest=1`.
  - Required: `o_m_read=0` immediately; after release, a read of the prior address misses.
- With `ICACHE_STATS_EN`: run 1 miss followed by 4 hits -> `o_miss_cnt=1`, `o_hit_cnt=4`.
